// File: rtl/div_arbiter.sv
// Round-robin owner selection for one shared tick divider.
// Each grant issues PULSES ticks at the owner's latched divide ratio.
module div_arbiter #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 8,
    parameter int PULSES = 4,
    parameter int PW     = $clog2(PULSES + 1)
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   div_val,
    output logic [NREQ-1:0]         grant,
    output logic                    tick_out,
    output logic                    busy,
    output logic                    done
);

    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [RW-1:0]     owner_q, owner_d;
    logic [RW-1:0]     rr_q, rr_d;
    logic [WIDTH-1:0]  div_q, div_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]     pcnt_q, pcnt_d;

    logic              found;
    logic [RW-1:0]     sel;
    int unsigned       idx;
    logic [WIDTH-1:0]  sel_val;
    logic              last_cnt;
    logic              last_p;

    // First requester at or above the rr pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        sel   = rr_q;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_q) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = RW'(idx);
            end
        end
    end

    assign sel_val  = div_val[int'(sel)*WIDTH +: WIDTH];
    assign last_cnt = (cnt_q == div_q - WIDTH'(1));
    assign last_p   = (pcnt_q == PW'(PULSES - 1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        pcnt_d  = pcnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = RUN;
                    grant_d = NREQ'(1) << sel;
                    owner_d = sel;
                    div_d   = (sel_val == '0) ? WIDTH'(1) : sel_val;
                    cnt_d   = '0;
                    pcnt_d  = '0;
                    rr_d    = (sel == RW'(NREQ - 1)) ? '0 : sel + RW'(1);
                end
            end
            RUN: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                    pcnt_d  = '0;
                end else if (last_cnt) begin
                    cnt_d = '0;
                    if (last_p) begin
                        state_d = DONE;
                        grant_d = '0;
                        pcnt_d  = '0;
                    end else begin
                        pcnt_d = pcnt_q + PW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            rr_q    <= '0;
            div_q   <= WIDTH'(1);
            cnt_q   <= '0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign grant    = grant_q;
    assign busy     = |grant_q;
    assign tick_out = (state_q == RUN) && (cnt_q == '0);
    assign done     = (state_q == DONE);

endmodule
